// File: rtl/fifo_flag_ctrl.sv
// fifo_flag_ctrl
//   Occupancy and flag controller for the FIFO. Qualifies raw client
//   write/read requests into address-counter enables and keeps a
//   registered fill level with full/empty/almost-full/almost-empty flags
//   that are always consistent with fill_level on the same cycle.
//
//   Optional feature: define FIFO_ERR_FLAGS_EN to build sticky
//   overflow/underflow registers cleared by err_clr. Without it,
//   overflow/underflow are tied to 0 and err_clr is ignored.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   wr_req       : client write request
//   rd_req       : client read request
//   err_clr      : clears sticky error flags (FIFO_ERR_FLAGS_EN only)
//   cw_en        : write accepted / write-address counter enable
//   cr_en        : read accepted / read-address counter enable
//   full         : registered, fill_level == MEMORY_DEPTH
//   empty        : registered, fill_level == 0
//   almost_full  : registered, fill_level >= AF_LEVEL
//   almost_empty : registered, fill_level <= AE_LEVEL
//   fill_level   : registered entry count, 0..MEMORY_DEPTH
//   overflow     : sticky, write requested while full
//   underflow    : sticky, read requested while empty

module fifo_flag_ctrl #(
    parameter int MEMORY_DEPTH      = 4,
    parameter int FIFO_ADDRESS_SIZE = 2,
    parameter int AF_LEVEL          = 3,
    parameter int AE_LEVEL          = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic                       rd_req,
    input  logic                       err_clr,
    output logic                       cw_en,
    output logic                       cr_en,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [FIFO_ADDRESS_SIZE:0] fill_level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LW = FIFO_ADDRESS_SIZE + 1;

    localparam logic [FIFO_ADDRESS_SIZE:0] DEPTH_C = LW'(MEMORY_DEPTH);
    localparam logic [FIFO_ADDRESS_SIZE:0] AF_C    = LW'(AF_LEVEL);
    localparam logic [FIFO_ADDRESS_SIZE:0] AE_C    = LW'(AE_LEVEL);
    localparam logic [FIFO_ADDRESS_SIZE:0] ONE_C   = LW'(1);

    logic [FIFO_ADDRESS_SIZE:0] level_next;

    // Acceptance uses the registered flags only; reset blocks both so the
    // downstream address counters never advance during reset.
    always_comb begin
        cw_en = wr_req & ~full  & ~rst;
        cr_en = rd_req & ~empty & ~rst;
    end

    always_comb begin
        level_next = fill_level;
        if (cw_en && !cr_en) begin
            level_next = fill_level + ONE_C;
        end else if (cr_en && !cw_en) begin
            level_next = fill_level - ONE_C;
        end
    end

    // Flags are derived from level_next so they land on the same edge as
    // fill_level instead of trailing it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_level   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_C == '0);
            almost_empty <= 1'b1;
        end else begin
            fill_level   <= level_next;
            full         <= (level_next == DEPTH_C);
            empty        <= (level_next == '0);
            almost_full  <= (level_next >= AF_C);
            almost_empty <= (level_next <= AE_C);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Clear outranks set: an error arriving with err_clr is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
    end
`endif

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Testbench for fifo_flag_ctrl: directed boundary sequence followed by
// randomized request traffic, checked against an integer occupancy model.
module tb_fifo_flag_ctrl;

    localparam int MD = 4;
    localparam int AW = 2;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          err_clr = 1'b0;
    logic          cw_en, cr_en, full, empty, almost_full, almost_empty;
    logic [AW:0]   fill_level;
    logic          overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    int  m_count = 0;
    bit  m_ovf = 0;
    bit  m_udf = 0;

    fifo_flag_ctrl #(
        .MEMORY_DEPTH      (MD),
        .FIFO_ADDRESS_SIZE (AW),
        .AF_LEVEL          (AF),
        .AE_LEVEL          (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .cw_en        (cw_en),
        .cr_en        (cr_en),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check acceptance before the edge,
    // advance the model, check registered outputs after the edge.
    task automatic step(input bit w, input bit r, input bit c, input bit rs);
        bit exp_cw, exp_cr;
        wr_req  = w;
        rd_req  = r;
        err_clr = c;
        rst     = rs;
        #2;
        exp_cw = w && !rs && (m_count < MD);
        exp_cr = r && !rs && (m_count > 0);
        check_eq("cw_en", int'(cw_en), int'(exp_cw));
        check_eq("cr_en", int'(cr_en), int'(exp_cr));

        if (rs) begin
            m_count = 0;
            m_ovf   = 0;
            m_udf   = 0;
        end else begin
            if (c) begin
                m_ovf = 0;
                m_udf = 0;
            end else begin
                if (w && m_count == MD) m_ovf = 1;
                if (r && m_count == 0)  m_udf = 1;
            end
            m_count = m_count + int'(exp_cw) - int'(exp_cr);
        end

        @(posedge clk);
        #1;
        check_eq("fill_level",   int'(fill_level),   m_count);
        check_eq("full",         int'(full),         int'(m_count == MD));
        check_eq("empty",        int'(empty),        int'(m_count == 0));
        check_eq("almost_full",  int'(almost_full),  int'(m_count >= AF));
        check_eq("almost_empty", int'(almost_empty), int'(m_count <= AE));
`ifdef FIFO_ERR_FLAGS_EN
        check_eq("overflow",     int'(overflow),     int'(m_ovf));
        check_eq("underflow",    int'(underflow),    int'(m_udf));
`else
        check_eq("overflow",     int'(overflow),     0);
        check_eq("underflow",    int'(underflow),    0);
`endif
    endtask

    initial begin
        @(posedge clk);
        #1;

        // reset with both requests held high
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);

        // fill to full, then one write too many
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

        // error clear, then clear coincident with write-while-full
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);

        // simultaneous at full
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);

        // drain, then one read too many
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

        // simultaneous at empty, then at level 2
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // mid-operation reset at level 3 with a write pending
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
